// File: rtl/controle_escrita_entrada.sv
// ----------------------------------------------------------------------------
// controle_escrita_entrada
//
// Write-back controller for the register file of a simple single-cycle CPU.
// It decides when the register file is written and from which source. ALU
// results are written immediately. Loads from memory wait for the data-memory
// latency. Input instructions freeze the CPU until the user confirms the
// switch value with a debounced push of the confirm button.
//
// Parameters
//   LATENCIA_MEM        extra read-latency cycles of the data memory (0..15)
//   N_DEBOUNCE          stable cycles needed to accept a button level (1..65535)
//
// Ports
//   clock               sole clock, rising edge
//   reset               asynchronous reset, active low
//   instr_valida        current instruction is valid
//   escrita_solicitada  decoder requests a register-file write
//   tipo_escrita        write source: 0 ULA, 1 memoria, 2 entrada, 3 none
//   botao_entrada       raw asynchronous confirm button, active high
//   chaves              switch value read by an input instruction
//   mux_ESCRITA         write-back source select (never 3)
//   escrita_reg         register-file write enable
//   congela_pc          holds PC and instruction while 1
//   dado_entrada        latched switch value, zero-extended to 32 bits
//   aguardando_entrada  waiting-for-user indicator (LED)
// ----------------------------------------------------------------------------
module controle_escrita_entrada #(
    parameter int LATENCIA_MEM = 1,
    parameter int N_DEBOUNCE   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valida,
    input  logic        escrita_solicitada,
    input  logic [1:0]  tipo_escrita,
    input  logic        botao_entrada,
    input  logic [15:0] chaves,
    output logic [1:0]  mux_ESCRITA,
    output logic        escrita_reg,
    output logic        congela_pc,
    output logic [31:0] dado_entrada,
    output logic        aguardando_entrada
);

    typedef enum logic [1:0] {
        EXECUTA,
        ESPERA_MEM,
        ESPERA_ENTRADA,
        ESCREVE_ENTRADA
    } estado_t;

    localparam logic [3:0]  LAT_CARGA  = 4'(LATENCIA_MEM);
    localparam logic [15:0] DEB_LIMITE = 16'(N_DEBOUNCE - 1);

    estado_t     estado_q, estado_d;
    logic [3:0]  latCnt_q, latCnt_d;
    logic        sync1_q, sync2_q;
    logic        debLevel_q, debLevel_d;
    logic [15:0] debCnt_q, debCnt_d;
    logic [31:0] dado_q, dado_d;
    logic        subidaDeb;
    logic        req;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= botao_entrada;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the accepted level flips only after N_DEBOUNCE consecutive
    // cycles of the opposite synchronized value. Any return to the current
    // level restarts the count. The rising edge is flagged in the same cycle
    // in which the level is about to flip, so the switches are sampled then.
    always_comb begin
        debCnt_d   = debCnt_q;
        debLevel_d = debLevel_q;
        subidaDeb  = 1'b0;
        if (sync2_q == debLevel_q) begin
            debCnt_d = '0;
        end else if (debCnt_q == DEB_LIMITE) begin
            debLevel_d = sync2_q;
            debCnt_d   = '0;
            subidaDeb  = sync2_q;
        end else begin
            debCnt_d = debCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            debLevel_q <= 1'b0;
            debCnt_q   <= '0;
        end else begin
            debLevel_q <= debLevel_d;
            debCnt_q   <= debCnt_d;
        end
    end

    assign req = instr_valida & escrita_solicitada & (tipo_escrita != 2'd3);

    // Next state and outputs. Instruction inputs are looked at only in
    // EXECUTA; the wait states ignore them because the instruction is frozen.
    // Debounced edges seen outside ESPERA_ENTRADA are simply dropped, so a
    // button already held on entry needs a release and a new press.
    // All outputs are forced low while reset is asserted, including the
    // combinational ALU write path, so an aborted wait never pulses a write.
    always_comb begin
        estado_d           = estado_q;
        latCnt_d           = latCnt_q;
        dado_d             = dado_q;
        mux_ESCRITA        = 2'd0;
        escrita_reg        = 1'b0;
        congela_pc         = 1'b0;
        aguardando_entrada = 1'b0;

        unique case (estado_q)
            EXECUTA: begin
                if (req) begin
                    case (tipo_escrita)
                        2'd0: begin
                            escrita_reg = 1'b1;
                        end
                        2'd1: begin
                            mux_ESCRITA = 2'd1;
                            if (LATENCIA_MEM == 0) begin
                                escrita_reg = 1'b1;
                            end else begin
                                congela_pc = 1'b1;
                                latCnt_d   = LAT_CARGA;
                                estado_d   = ESPERA_MEM;
                            end
                        end
                        2'd2: begin
                            mux_ESCRITA = 2'd2;
                            congela_pc  = 1'b1;
                            estado_d    = ESPERA_ENTRADA;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ESPERA_MEM: begin
                mux_ESCRITA = 2'd1;
                latCnt_d    = latCnt_q - 4'd1;
                if (latCnt_q <= 4'd1) begin
                    escrita_reg = 1'b1;
                    latCnt_d    = '0;
                    estado_d    = EXECUTA;
                end else begin
                    congela_pc = 1'b1;
                end
            end
            ESPERA_ENTRADA: begin
                mux_ESCRITA        = 2'd2;
                congela_pc         = 1'b1;
                aguardando_entrada = 1'b1;
                if (subidaDeb) begin
                    dado_d   = {16'b0, chaves};
                    estado_d = ESCREVE_ENTRADA;
                end
            end
            ESCREVE_ENTRADA: begin
                mux_ESCRITA = 2'd2;
                escrita_reg = 1'b1;
                estado_d    = EXECUTA;
            end
            default: begin
                estado_d = EXECUTA;
            end
        endcase

        if (!reset) begin
            mux_ESCRITA        = 2'd0;
            escrita_reg        = 1'b0;
            congela_pc         = 1'b0;
            aguardando_entrada = 1'b0;
        end
    end

    // FSM state, load-latency counter and latched input value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= EXECUTA;
            latCnt_q <= '0;
            dado_q   <= '0;
        end else begin
            estado_q <= estado_d;
            latCnt_q <= latCnt_d;
            dado_q   <= dado_d;
        end
    end

    assign dado_entrada = dado_q;

endmodule

// File: tb/tb_controle_escrita_entrada.sv
// ----------------------------------------------------------------------------
// tb_controle_escrita_entrada
//
// Directed self-checking bench for controle_escrita_entrada, built with
// LATENCIA_MEM = 2 and N_DEBOUNCE = 4. Inputs change one time unit after a
// rising edge and outputs are sampled one further unit later.
// ----------------------------------------------------------------------------
module tb_controle_escrita_entrada;

    logic        clock;
    logic        reset;
    logic        instr_valida;
    logic        escrita_solicitada;
    logic [1:0]  tipo_escrita;
    logic        botao_entrada;
    logic [15:0] chaves;
    logic [1:0]  mux_ESCRITA;
    logic        escrita_reg;
    logic        congela_pc;
    logic [31:0] dado_entrada;
    logic        aguardando_entrada;

    int checks = 0;
    int errors = 0;

    controle_escrita_entrada #(
        .LATENCIA_MEM(2),
        .N_DEBOUNCE  (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .instr_valida      (instr_valida),
        .escrita_solicitada(escrita_solicitada),
        .tipo_escrita      (tipo_escrita),
        .botao_entrada     (botao_entrada),
        .chaves            (chaves),
        .mux_ESCRITA       (mux_ESCRITA),
        .escrita_reg       (escrita_reg),
        .congela_pc        (congela_pc),
        .dado_entrada      (dado_entrada),
        .aguardando_entrada(aguardando_entrada)
    );

    // 10-unit clock period, first rising edge at t=5.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic es, input logic [1:0] tipo);
        instr_valida       = iv;
        escrita_solicitada = es;
        tipo_escrita       = tipo;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic esc, input logic cong,
                            input logic [1:0] mux, input logic agu);
        checkOutput({tag, ".escrita_reg"}, 32'(escrita_reg), 32'(esc));
        checkOutput({tag, ".congela_pc"}, 32'(congela_pc), 32'(cong));
        checkOutput({tag, ".mux_ESCRITA"}, 32'(mux_ESCRITA), 32'(mux));
        checkOutput({tag, ".aguardando"}, 32'(aguardando_entrada), 32'(agu));
    endtask

    // Runs n cycles and reports whether the block stayed in the input wait
    // (LED on, frozen, no write) on every one of them.
    task automatic holdWait(input int n, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            #1;
            if (!(aguardando_entrada === 1'b1 && congela_pc === 1'b1 && escrita_reg === 1'b0))
                ok = 1'b0;
        end
    endtask

    // Waits (bounded) for the write pulse; returns the cycle it appeared in,
    // or 21 on timeout, and whether the LED stayed on until then.
    task automatic waitForWrite(output int k, output logic aguOk);
        k     = 21;
        aguOk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            if (escrita_reg === 1'b1) begin
                k = i;
                break;
            end
            if (aguardando_entrada !== 1'b1)
                aguOk = 1'b0;
        end
    endtask

    // Directed sequence: reset, ALU write, no-write, load, input with
    // debounce, stale press and glitch rejection, reset during a wait.
    initial begin
        int   k;
        logic ok;

        reset         = 1'b0;
        botao_entrada = 1'b0;
        chaves        = 16'hA5C3;
        applyStimulus(1'b1, 1'b1, 2'd0);
        #3;
        checkAll("reset", 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("reset.dado", dado_entrada, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0);
        #1;
        checkAll("idle", 1'b0, 1'b0, 2'd0, 1'b0);

        // ALU write on three consecutive cycles
        applyStimulus(1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checkAll("alu", 1'b1, 1'b0, 2'd0, 1'b0);
        end

        // tipo 3 and no write request give no write
        applyStimulus(1'b1, 1'b1, 2'd3);
        #1;
        checkAll("tipo3", 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        #1;
        checkAll("nosolic", 1'b0, 1'b0, 2'd0, 1'b0);

        // Load with latency 2: three cycles, single write on the last
        tick();
        applyStimulus(1'b1, 1'b1, 2'd1);
        #1;
        checkAll("load0", 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        #1;
        checkAll("load1", 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        #1;
        checkAll("load2", 1'b1, 1'b0, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        tick();
        #1;
        checkAll("loadEnd", 1'b0, 1'b0, 2'd0, 1'b0);

        // Input instruction, press 10 cycles later and hold
        applyStimulus(1'b1, 1'b1, 2'd2);
        #1;
        checkAll("inIssue", 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 2'd0);
        #1;
        checkAll("inWait", 1'b0, 1'b1, 2'd2, 1'b1);
        holdWait(10, ok);
        checkOutput("inHold10", 32'(ok), 32'd1);
        botao_entrada = 1'b1;
        waitForWrite(k, ok);
        checkOutput("inLatency", 32'(k), 32'd6);
        checkOutput("inLedUntilWrite", 32'(ok), 32'd1);
        checkAll("inWrite", 1'b1, 1'b0, 2'd2, 1'b0);
        checkOutput("inDado", dado_entrada, 32'h0000A5C3);
        chaves = 16'h1234;
        applyStimulus(1'b0, 1'b0, 2'd0);
        tick();
        #1;
        checkAll("inDone", 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("inDadoKept", dado_entrada, 32'h0000A5C3);

        // Stale press: button still held when the next input instruction comes
        chaves = 16'h0F0F;
        applyStimulus(1'b1, 1'b1, 2'd2);
        #1;
        checkAll("staleIssue", 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0);
        holdWait(10, ok);
        checkOutput("staleHeld", 32'(ok), 32'd1);
        botao_entrada = 1'b0;
        holdWait(10, ok);
        checkOutput("staleRelease", 32'(ok), 32'd1);

        // 3-cycle glitch is below the debounce length
        botao_entrada = 1'b1;
        tick();
        tick();
        tick();
        botao_entrada = 1'b0;
        holdWait(10, ok);
        checkOutput("glitch", 32'(ok), 32'd1);
        checkOutput("glitchDado", dado_entrada, 32'h0000A5C3);

        // A real press now satisfies the wait
        botao_entrada = 1'b1;
        waitForWrite(k, ok);
        checkOutput("staleLatency", 32'(k), 32'd6);
        checkAll("staleWrite", 1'b1, 1'b0, 2'd2, 1'b0);
        checkOutput("staleDado", dado_entrada, 32'h00000F0F);
        tick();
        #1;
        checkAll("staleDone", 1'b0, 1'b0, 2'd0, 1'b0);
        botao_entrada = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Reset asserted in the middle of an input wait
        applyStimulus(1'b1, 1'b1, 2'd2);
        tick();
        applyStimulus(1'b1, 1'b1, 2'd0);
        #1;
        checkAll("rstWait", 1'b0, 1'b1, 2'd2, 1'b1);
        reset = 1'b0;
        #1;
        checkAll("rstMid", 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("rstMidDado", dado_entrada, 32'h0);
        tick();
        #1;
        checkAll("rstHeld", 1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b1;
        #1;
        checkAll("rstAlu", 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        #1;
        checkAll("rstAlu2", 1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("rstDadoAfter", dado_entrada, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
